// File: rtl/uart_tx_engine.sv
// UART transmit engine: byte FIFO feeding an 8-bit, LSB-first serialiser
// with optional parity, timed by a 16x oversample baud tick.
//
// Ports:
//   pclk, presetn            clock, asynchronous active-low reset
//   baud_tick                one-cycle pulse at OSR x the bit rate
//   write_en, data_tx        push strobe and byte
//   tx_thr_val               threshold select (level = tx_thr_val * 4)
//   ip_en                    transmitter enable
//   parity_en, parity_type   parity append enable, 0 = even / 1 = odd
//   tx                       serial line, idle high
//   tx_thr                   FIFO level at or below threshold
//   tx_full, tx_empty        FIFO occupancy flags
//   tx_busy                  frame in progress
module uart_tx_engine #(
    parameter int DEPTH = 16,
    parameter int OSR   = 16
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       baud_tick,
    input  logic       write_en,
    input  logic [7:0] data_tx,
    input  logic [1:0] tx_thr_val,
    input  logic       ip_en,
    input  logic       parity_en,
    input  logic       parity_type,
    output logic       tx,
    output logic       tx_thr,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(OSR);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] level;
    logic [7:0]    head;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    shift;
    logic [7:0]    shift_nxt;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_idx;
    logic          par_en_q;
    logic          par_bit;
    logic          tx_nxt;
    logic          busy_nxt;

    logic          push;
    logic          pop;
    logic          bit_done;

    assign head     = mem[rd_ptr];
    assign level    = CW'({tx_thr_val, 2'b00});
    // A push is gated on the live count, so an overflowing byte is dropped
    // even when a pop happens on the same edge.
    assign push     = write_en & (count != CW'(DEPTH));
    assign pop      = (state == IDLE) & ip_en & ~tx_empty;
    assign bit_done = baud_tick & (tick_cnt == TW'(OSR - 1));

    // ---------------- FIFO storage ----------------
    always_ff @(posedge pclk) begin
        if (push) begin
            mem[wr_ptr] <= data_tx;
        end
    end

    // Flags are registered from the count before this edge's update, so a
    // push or pop shows up on the flags one edge after it happens.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx_full  <= 1'b0;
            tx_empty <= 1'b1;
            tx_thr   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count    <= count + CW'(push) - CW'(pop);
            tx_full  <= (count == CW'(DEPTH));
            tx_empty <= (count == '0);
            tx_thr   <= ip_en & (count <= level);
        end
    end

    // ---------------- frame datapath ----------------
    always_comb begin
        shift_nxt = shift;
        if (pop) begin
            shift_nxt = head;
        end else if ((state == DATA) && bit_done) begin
            shift_nxt = {1'b0, shift[7:1]};
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            shift    <= '0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            par_en_q <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            shift <= shift_nxt;
            if (pop) begin
                // Parity settings are frozen for the whole frame here.
                tick_cnt <= '0;
                bit_idx  <= '0;
                par_en_q <= parity_en;
                par_bit  <= (^head) ^ parity_type;
            end else if ((state != IDLE) && baud_tick) begin
                tick_cnt <= bit_done ? '0 : tick_cnt + TW'(1);
                if ((state == DATA) && bit_done) begin
                    bit_idx <= bit_idx + 3'd1;
                end
            end
        end
    end

    // ---------------- frame FSM ----------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            state   <= state_nxt;
            tx      <= tx_nxt;
            tx_busy <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_done && (bit_idx == 3'd7)) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Line level is decided from the next state so tx changes on the same
    // edge as the state it belongs to.
    always_comb begin
        tx_nxt   = 1'b1;
        busy_nxt = (state_nxt != IDLE);
        unique case (state_nxt)
            IDLE:    tx_nxt = 1'b1;
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            PARITY:  tx_nxt = par_bit;
            STOP:    tx_nxt = 1'b1;
            default: tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Testbench for uart_tx_engine: directed steps with a frame scoreboard.
// Expected frames are queued at push time and decoded off tx.
module tb_uart_tx_engine;

    logic       pclk;
    logic       presetn;
    logic       baud_tick;
    logic       write_en;
    logic [7:0] data_tx;
    logic [1:0] tx_thr_val;
    logic       ip_en;
    logic       parity_en;
    logic       parity_type;
    logic       tx;
    logic       tx_thr;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_busy;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       pt;
    } frame_t;

    frame_t sb[$];
    int     passed = 0;
    int     total  = 0;
    bit     tick_hold = 0;
    int     tdiv = 0;

    uart_tx_engine #(.DEPTH(16), .OSR(16)) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .baud_tick  (baud_tick),
        .write_en   (write_en),
        .data_tx    (data_tx),
        .tx_thr_val (tx_thr_val),
        .ip_en      (ip_en),
        .parity_en  (parity_en),
        .parity_type(parity_type),
        .tx         (tx),
        .tx_thr     (tx_thr),
        .tx_full    (tx_full),
        .tx_empty   (tx_empty),
        .tx_busy    (tx_busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Baud tick: every third cycle, or held high when tick_hold is set.
    always @(negedge pclk) begin
        if (tick_hold) begin
            baud_tick <= 1'b1;
        end else begin
            tdiv      <= (tdiv == 2) ? 0 : tdiv + 1;
            baud_tick <= (tdiv == 2);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] b, input bit track);
        frame_t f;
        @(negedge pclk);
        write_en = 1'b1;
        data_tx  = b;
        @(negedge pclk);
        write_en = 1'b0;
        if (track) begin
            f.d  = b;
            f.pe = parity_en;
            f.pt = parity_type;
            sb.push_back(f);
        end
    endtask

    task automatic wait_tick(output bit ok);
        int i = 0;
        do begin
            @(posedge pclk);
            i++;
        end while (baud_tick !== 1'b1 && i < 50);
        ok = (baud_tick === 1'b1);
        #1;
    endtask

    task automatic wait_busy(input logic v, input string tag);
        int i = 0;
        do begin
            @(posedge pclk);
            #1;
            i++;
        end while (tx_busy !== v && i < 10000);
        chk(tag, tx_busy, v);
    endtask

    // Decode one frame from tx and compare against the scoreboard head.
    task automatic recv(output int waited);
        frame_t      f;
        logic [10:0] bits;
        int          n;
        bit          ok;
        waited = 0;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
            return;
        end
        f = sb.pop_front();
        while (tx !== 1'b0 && waited < 5000) begin
            @(negedge pclk);
            waited++;
        end
        chk("start_seen", tx, 0);
        if (tx !== 1'b0) return;
        n = f.pe ? 11 : 10;
        if (f.pe) bits = {1'b1, (^f.d) ^ f.pt, f.d, 1'b0};
        else      bits = {1'b0, 1'b1, f.d, 1'b0};
        for (int b = 0; b < n; b++) begin
            for (int t = 1; t <= 16; t++) begin
                wait_tick(ok);
                if (!ok) begin
                    chk("tick_timeout", 0, 1);
                    return;
                end
                if (t == 8 || t == 15) begin
                    chk($sformatf("bit%0d_d%0h", b, f.d), tx, bits[b]);
                end
            end
        end
        chk("busy_end", tx_busy, 0);
    endtask

    initial begin
        int w;
        int zeros;
        presetn     = 1'b0;
        write_en    = 1'b0;
        data_tx     = 8'h00;
        tx_thr_val  = 2'b00;
        ip_en       = 1'b0;
        parity_en   = 1'b0;
        parity_type = 1'b0;

        // reset values
        repeat (3) @(negedge pclk);
        chk("rst_tx", tx, 1);
        chk("rst_thr", tx_thr, 0);
        chk("rst_full", tx_full, 0);
        chk("rst_empty", tx_empty, 1);
        chk("rst_busy", tx_busy, 0);
        presetn = 1'b1;

        // start latency
        ip_en = 1'b1;
        push(8'h3C, 0);
        @(posedge pclk); #1;
        chk("lat_empty_n1", tx_empty, 0);
        chk("lat_tx_n1", tx, 1);
        @(posedge pclk); #1;
        chk("lat_tx_n2", tx, 0);
        chk("lat_busy_n2", tx_busy, 1);
        chk("lat_empty_n2", tx_empty, 0);
        @(posedge pclk); #1;
        chk("lat_empty_n3", tx_empty, 1);
        wait_busy(0, "lat_done");

        // single frame, no parity
        push(8'hA5, 1);
        recv(w);

        // parity, tick held high
        tick_hold = 1;
        parity_en = 1'b1;
        parity_type = 1'b0;
        push(8'h07, 1);
        recv(w);
        parity_type = 1'b1;
        push(8'h07, 1);
        recv(w);
        parity_type = 1'b0;
        push(8'h07, 1);
        fork
            recv(w);
            begin
                repeat (40) @(negedge pclk);
                parity_type = 1'b1;
            end
        join
        parity_type = 1'b0;
        parity_en   = 1'b0;
        tick_hold   = 0;

        // fill and overflow
        ip_en = 1'b0;
        for (int i = 0; i < 15; i++) push(8'(i), 1);
        @(posedge pclk); #1;
        chk("full_at15", tx_full, 0);
        push(8'h0F, 1);
        @(posedge pclk); #1;
        chk("full_at16", tx_full, 1);
        push(8'h10, 0);
        @(posedge pclk); #1;
        chk("full_ovf", tx_full, 1);
        chk("empty_ovf", tx_empty, 0);
        @(negedge pclk);
        ip_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            recv(w);
            if (i > 0) chk($sformatf("gap%0d", i), (w <= 2), 1);
        end
        @(posedge pclk); #1;
        chk("drain_empty", tx_empty, 1);

        // threshold
        ip_en = 1'b0;
        tx_thr_val = 2'b01;
        for (int i = 0; i < 6; i++) push(8'h60 + 8'(i), 0);
        @(posedge pclk); #1;
        chk("thr_dis", tx_thr, 0);
        @(negedge pclk);
        ip_en = 1'b1;
        @(posedge pclk); #1;
        chk("thr_c6", tx_thr, 0);
        chk("thr_pop1", tx_busy, 1);
        @(posedge pclk); #1;
        chk("thr_c5", tx_thr, 0);
        wait_busy(0, "thr_f1_end");
        wait_busy(1, "thr_f2_start");
        chk("thr_c5b", tx_thr, 0);
        @(posedge pclk); #1;
        chk("thr_c4", tx_thr, 1);
        @(negedge pclk);
        tx_thr_val = 2'b00;
        @(posedge pclk); #1;
        chk("thr0_c4", tx_thr, 0);
        w = 0;
        while (tx_empty !== 1'b1 && w < 10000) begin
            @(posedge pclk); #1;
            w++;
        end
        chk("thr0_empty", tx_empty, 1);
        chk("thr0_c0", tx_thr, 1);
        wait_busy(0, "thr_done");

        // simultaneous push and pop at count 3
        ip_en = 1'b0;
        tx_thr_val = 2'b01;
        for (int i = 0; i < 3; i++) push(8'h90 + 8'(i), 1);
        @(posedge pclk);
        @(negedge pclk);
        ip_en    = 1'b1;
        write_en = 1'b1;
        data_tx  = 8'hC3;
        sb.push_back('{d: 8'hC3, pe: 1'b0, pt: 1'b0});
        fork
            recv(w);
            begin
                @(posedge pclk);
                @(negedge pclk);
                write_en = 1'b0;
                @(posedge pclk); #1;
                chk("pp_thr", tx_thr, 1);
                chk("pp_empty", tx_empty, 0);
                chk("pp_full", tx_full, 0);
            end
        join
        for (int i = 0; i < 3; i++) recv(w);
        chk("sb_drained", sb.size(), 0);

        // reset mid-frame
        push(8'h55, 0);
        push(8'hAA, 0);
        repeat (30) @(negedge pclk);
        chk("mid_busy", tx_busy, 1);
        #3;
        presetn = 1'b0;
        #1;
        chk("arst_tx", tx, 1);
        chk("arst_empty", tx_empty, 1);
        chk("arst_busy", tx_busy, 0);
        @(negedge pclk);
        presetn = 1'b1;
        zeros = 0;
        repeat (600) begin
            @(negedge pclk);
            if (tx !== 1'b1) zeros++;
        end
        chk("arst_noframe", zeros, 0);
        chk("arst_idle", tx_busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
